controlador_acesso_perfil: RTL and testbench
============================================

Name: controlador_acesso_perfil

Overview:
- Sequential access controller for the profile/function permission check.
- Takes one request at a time (profile and requested function) and evaluates it against a per-profile permission mask.
- Grants the function for a bounded window, or denies the request.
- Locks out all requests after repeated consecutive failures.
- Sits between the user-interface input logic and the function-enable lines of the interface datapath.

Parameters:
- FUNC_W, 4: width of the function code; number of functions = 2^FUNC_W.
- PERM_MASK_P0, 16'h000F: permitted-function mask for profile 0; bit i = function i allowed.
- PERM_MASK_P1, 16'h00FF: permitted-function mask for profile 1.
- PERM_MASK_P2, 16'h0F0F: permitted-function mask for profile 2.
- PERM_MASK_P3, 16'hFFFF: permitted-function mask for profile 3.
- GRANT_CYCLES, 4: length of the grant window, in cycles.
- MAX_FAILS, 3: number of consecutive denials that triggers lockout; legal range 1..7.
- LOCK_CYCLES, 8: length of the lockout, in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  1  request strobe; sampled only in IDLE.
- perfil  in  2  requesting profile; latched with req.
- funcao  in  FUNC_W  requested function code; latched with req.
- release  in  1  ends an active grant early.
- busy  out  1  high in every state except IDLE.
- grant  out  1  high during the grant window.
- func_enable  out  2^FUNC_W  one-hot enable of the granted function; zero outside GRANT.
- deny  out  1  one-cycle pulse on a denial.
- locked  out  1  high during lockout.
- fail_cnt  out  3  current consecutive-failure count.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clock edge), effective at any point including mid-grant or mid-lock:
  - state=IDLE;
  - busy, grant, deny, locked = 0;
  - func_enable = 0;
  - fail_cnt = 0;
  - latched perfil/funcao = 0;
  - window counter = 0.
- IDLE:
  - req=1 at edge k: latch perfil/funcao, go to CHECK; busy=1 after edge k.
  - req=0: stay in IDLE.
- CHECK (exactly one cycle): look up allowed = PERM_MASK_P[perfil][funcao].
  - allowed=1: go to GRANT; fail_cnt := 0; grant=1 and func_enable=(1<<funcao) after edge k+1.
  - allowed=0 and fail_cnt+1 < MAX_FAILS: go to DENY; fail_cnt := fail_cnt+1.
  - allowed=0 and fail_cnt+1 = MAX_FAILS: go to LOCK; fail_cnt := MAX_FAILS; locked=1.
- GRANT:
  - Window counter is loaded with GRANT_CYCLES-1 on entry and decrements each cycle.
  - Exit to IDLE on the edge where the counter=0 or release=1, whichever comes first; grant/func_enable clear on that same edge.
  - release and timeout together: single exit, no extra cycle.
  - Grant lasts exactly GRANT_CYCLES cycles when release is not asserted.
- DENY: deny=1 for exactly one cycle, then IDLE.
- LOCK:
  - locked=1 for exactly LOCK_CYCLES cycles.
  - On exit to IDLE: fail_cnt := 0, locked := 0.
- req is ignored in CHECK, GRANT, DENY and LOCK; it is not queued. A req still held high on return to IDLE is accepted on the next edge.
- release is ignored outside GRANT.
- Request latency: req at edge k → grant or deny visible after edge k+1 (two-cycle turnaround into IDLE minimum).
- fail_cnt counts consecutive denials across all profiles; any grant clears it. Saturates at MAX_FAILS.
- Out-of-range or unknown inputs never assert grant: X in the lookup is treated as allowed=0.

Optional Feature:
- Macro: AUDIT_COUNT_EN.
- When defined, two extra outputs are added:
  - grant_total (8 bits): increments on each CHECK→GRANT.
  - deny_total (8 bits): increments on each CHECK→DENY or CHECK→LOCK.
  - Both saturate at 8'hFF and clear only on reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then perfil=1, funcao=5, req pulse → grant=1 and func_enable=16'h0020 for 4 cycles, then IDLE; fail_cnt=0.
- perfil=0, funcao=9 → deny pulse of 1 cycle, fail_cnt=1; repeat twice → third failure gives locked=1 for 8 cycles, then fail_cnt=0 and IDLE.
- Two denials, then perfil=3, funcao=15 → grant, fail_cnt returns to 0; a further denial leaves fail_cnt=1 (no lock).
- Grant for perfil=2, funcao=8; release=1 on the 2nd grant cycle → grant low after that edge; req held high throughout is accepted immediately after return to IDLE.
- rst_n=0 mid-GRANT and mid-LOCK → all outputs 0 and state IDLE on the next edge; req during LOCK is ignored (no grant, no deny).
- With AUDIT_COUNT_EN: 3 grants + 2 denials → grant_total=3, deny_total=2; 300 grants → grant_total=255.

Source files
------------

// File: rtl/controlador_acesso_perfil.sv
// Profile/function access controller: permission lookup, timed grant window, lockout.
// Optional macro AUDIT_COUNT_EN adds saturating grant_total_o / deny_total_o counters.
module controlador_acesso_perfil #(
  parameter int                       FUNC_W       = 4,
  parameter logic [(1<<FUNC_W)-1:0]   PERM_MASK_P0 = 16'h000F,
  parameter logic [(1<<FUNC_W)-1:0]   PERM_MASK_P1 = 16'h00FF,
  parameter logic [(1<<FUNC_W)-1:0]   PERM_MASK_P2 = 16'h0F0F,
  parameter logic [(1<<FUNC_W)-1:0]   PERM_MASK_P3 = 16'hFFFF,
  parameter int                       GRANT_CYCLES = 4,
  parameter int                       MAX_FAILS    = 3,
  parameter int                       LOCK_CYCLES  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       req_i,
  input  logic [1:0]                 perfil_i,
  input  logic [FUNC_W-1:0]          funcao_i,
  input  logic                       release_i,
  output logic                       busy_o,
  output logic                       grant_o,
  output logic [(1<<FUNC_W)-1:0]     func_enable_o,
  output logic                       deny_o,
  output logic                       locked_o,
  output logic [2:0]                 fail_cnt_o
`ifdef AUDIT_COUNT_EN
  ,
  output logic [7:0]                 grant_total_o,
  output logic [7:0]                 deny_total_o
`endif
);

  localparam int N_FUNC  = 1 << FUNC_W;
  localparam int WIN_MAX = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int CNT_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

  localparam logic [CNT_W-1:0] GRANT_LOAD  = CNT_W'(GRANT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]       MAX_FAILS_C = 3'(MAX_FAILS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_GRANT = 3'd2,
    ST_DENY  = 3'd3,
    ST_LOCK  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          perfil_q, perfil_d;
  logic [FUNC_W-1:0]   funcao_q, funcao_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          fail_q, fail_d;
  logic                busy_q, busy_d;
  logic                grant_q, grant_d;
  logic [N_FUNC-1:0]   fe_q, fe_d;
  logic                deny_q, deny_d;
  logic                locked_q, locked_d;

  logic [N_FUNC-1:0]   mask_s;
  logic                allowed_s;
  logic [2:0]          fail_next_s;

  function automatic logic [N_FUNC-1:0] perm_mask(input logic [1:0] p);
    case (p)
      2'd0:    perm_mask = PERM_MASK_P0;
      2'd1:    perm_mask = PERM_MASK_P1;
      2'd2:    perm_mask = PERM_MASK_P2;
      2'd3:    perm_mask = PERM_MASK_P3;
      default: perm_mask = '0;
    endcase
  endfunction

  assign mask_s      = perm_mask(perfil_q);
  assign allowed_s   = mask_s[funcao_q];
  assign fail_next_s = fail_q + 3'd1;

  // Next-state logic; the output registers are loaded from the upcoming state so they align with it.
  always_comb begin
    state_d  = state_q;
    perfil_d = perfil_q;
    funcao_d = funcao_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i == 1'b1) begin
          state_d  = ST_CHECK;
          perfil_d = perfil_i;
          funcao_d = funcao_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // An unknown lookup result fails the equality test and takes the denial path.
        if (allowed_s == 1'b1) begin
          state_d = ST_GRANT;
          fail_d  = 3'd0;
          cnt_d   = GRANT_LOAD;
        end else if (fail_next_s < MAX_FAILS_C) begin
          state_d = ST_DENY;
          fail_d  = fail_next_s;
        end else begin
          state_d = ST_LOCK;
          fail_d  = MAX_FAILS_C;
          cnt_d   = LOCK_LOAD;
        end
      end
      ST_GRANT: begin
        if ((cnt_q == '0) || (release_i == 1'b1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DENY: begin
        state_d = ST_IDLE;
      end
      ST_LOCK: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          fail_d  = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    grant_d  = (state_d == ST_GRANT);
    deny_d   = (state_d == ST_DENY);
    locked_d = (state_d == ST_LOCK);
    if (state_d == ST_GRANT) begin
      fe_d = N_FUNC'(1) << funcao_d;
    end else begin
      fe_d = '0;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      perfil_q <= 2'd0;
      funcao_q <= '0;
      cnt_q    <= '0;
      fail_q   <= 3'd0;
      busy_q   <= 1'b0;
      grant_q  <= 1'b0;
      fe_q     <= '0;
      deny_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      perfil_q <= perfil_d;
      funcao_q <= funcao_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      fe_q     <= fe_d;
      deny_q   <= deny_d;
      locked_q <= locked_d;
    end
  end

  assign busy_o        = busy_q;
  assign grant_o       = grant_q;
  assign func_enable_o = fe_q;
  assign deny_o        = deny_q;
  assign locked_o      = locked_q;
  assign fail_cnt_o    = fail_q;

`ifdef AUDIT_COUNT_EN
  logic [7:0] grant_total_q, grant_total_d;
  logic [7:0] deny_total_q, deny_total_d;

  // Saturating audit totals, counted on the CHECK decision.
  always_comb begin
    grant_total_d = grant_total_q;
    deny_total_d  = deny_total_q;
    if ((state_q == ST_CHECK) && (state_d == ST_GRANT) && (grant_total_q != 8'hFF)) begin
      grant_total_d = grant_total_q + 8'd1;
    end else begin
      grant_total_d = grant_total_q;
    end
    if ((state_q == ST_CHECK) && ((state_d == ST_DENY) || (state_d == ST_LOCK)) &&
        (deny_total_q != 8'hFF)) begin
      deny_total_d = deny_total_q + 8'd1;
    end else begin
      deny_total_d = deny_total_q;
    end
  end

  // Audit total registers; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      grant_total_q <= 8'd0;
      deny_total_q  <= 8'd0;
    end else begin
      grant_total_q <= grant_total_d;
      deny_total_q  <= deny_total_d;
    end
  end

  assign grant_total_o = grant_total_q;
  assign deny_total_o  = deny_total_q;
`endif

endmodule

// File: tb/tb_controlador_acesso_perfil.sv
// Bench for controlador_acesso_perfil: per-cycle vector table with an expected-value queue,
// plus hand-written latency/window and (with AUDIT_COUNT_EN) audit-counter sequences.
module tb_controlador_acesso_perfil;

  logic        clk, rst_n, req, rel;
  logic [1:0]  perfil;
  logic [3:0]  funcao;
  logic        busy, grant, deny, locked;
  logic [15:0] fe;
  logic [2:0]  fail;
`ifdef AUDIT_COUNT_EN
  logic [7:0]  gtot, dtot;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic [1:0]  p;
    logic [3:0]  f;
    logic        rel;
    logic        rst;
    logic [22:0] exp;   // {busy, grant, func_enable, deny, locked, fail_cnt}
  } vec_t;

  vec_t        vecs[$];
  logic [22:0] sb[$];

  controlador_acesso_perfil dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_i         (req),
    .perfil_i      (perfil),
    .funcao_i      (funcao),
    .release_i     (rel),
    .busy_o        (busy),
    .grant_o       (grant),
    .func_enable_o (fe),
    .deny_o        (deny),
    .locked_o      (locked),
    .fail_cnt_o    (fail)
`ifdef AUDIT_COUNT_EN
    ,
    .grant_total_o (gtot),
    .deny_total_o  (dtot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int r, input int p, input int f, input int rl, input int rs,
                     input int eb, input int eg, input int efe, input int ed, input int el,
                     input int ef);
    vec_t v;
    v.req = 1'(r);
    v.p   = 2'(p);
    v.f   = 4'(f);
    v.rel = 1'(rl);
    v.rst = 1'(rs);
    v.exp = {1'(eb), 1'(eg), 16'(efe), 1'(ed), 1'(el), 3'(ef)};
    vecs.push_back(v);
  endtask

`ifdef AUDIT_COUNT_EN
  task automatic do_req(input int p, input int f);
    int n;
    @(negedge clk);
    req = 1'b1; perfil = 2'(p); funcao = 4'(f);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("do_req_timeout", 32'(busy), 32'd0);
  endtask
`endif

  initial begin
    logic [22:0] got, exp;
    int lat, glen;

    req = 1'b0; rel = 1'b0; perfil = 2'd0; funcao = 4'd0; rst_n = 1'b0;

    // reset
    for (int i = 0; i < 2; i++) add(0,0,0,0,0, 0,0,0,0,0,0);
    // grant p1 f5: 4-cycle window, then idle
    add(1,1,5,0,1, 1,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,1, 1,1,'h0020,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);
    // two denials (release asserted outside GRANT is ignored), then lockout
    for (int k = 1; k <= 2; k++) begin
      add(1,0,9,1,1, 1,0,0,0,0,k-1);
      add(0,0,9,1,1, 1,0,0,1,0,k);
      add(0,0,9,1,1, 0,0,0,0,0,k);
    end
    add(1,0,9,0,1, 1,0,0,0,0,2);
    for (int i = 0; i < 8; i++) add((i >= 2 && i <= 5) ? 1 : 0,3,15,0,1, 1,0,0,0,1,3);
    add(0,0,0,0,1, 0,0,0,0,0,0);
    // two denials, a grant clears fail_cnt, one more denial leaves 1
    add(1,1,12,0,1, 1,0,0,0,0,0); add(0,1,12,0,1, 1,0,0,1,0,1); add(0,1,12,0,1, 0,0,0,0,0,1);
    add(1,1,12,0,1, 1,0,0,0,0,1); add(0,1,12,0,1, 1,0,0,1,0,2); add(0,1,12,0,1, 0,0,0,0,0,2);
    add(1,3,15,0,1, 1,0,0,0,0,2);
    for (int i = 0; i < 4; i++) add(0,0,0,0,1, 1,1,'h8000,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);
    add(1,2,4,0,1, 1,0,0,0,0,0); add(0,2,4,0,1, 1,0,0,1,0,1); add(0,2,4,0,1, 0,0,0,0,0,1);
    // early release on 2nd grant cycle with req held; then release coinciding with timeout
    add(1,2,8,0,1, 1,0,0,0,0,1);
    add(1,2,8,0,1, 1,1,'h0100,0,0,0);
    add(1,2,8,0,1, 1,1,'h0100,0,0,0);
    add(1,2,8,1,1, 0,0,0,0,0,0);
    add(1,2,8,0,1, 1,0,0,0,0,0);
    add(0,0,0,0,1, 1,1,'h0100,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,1, 1,1,'h0100,0,0,0);
    add(0,0,0,1,1, 0,0,0,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);
    // reset mid-GRANT
    add(1,3,0,0,1, 1,0,0,0,0,0);
    add(0,3,0,0,1, 1,1,'h0001,0,0,0);
    add(0,3,0,0,1, 1,1,'h0001,0,0,0);
    add(1,3,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);
    // reset mid-LOCK, with req asserted together with reset
    for (int k = 1; k <= 2; k++) begin
      add(1,0,4,0,1, 1,0,0,0,0,k-1);
      add(0,0,4,0,1, 1,0,0,1,0,k);
      add(0,0,4,0,1, 0,0,0,0,0,k);
    end
    add(1,0,4,0,1, 1,0,0,0,0,2);
    add(0,0,4,0,1, 1,0,0,0,1,3);
    add(0,0,4,0,1, 1,0,0,0,1,3);
    add(1,3,15,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      req = vecs[i].req; perfil = vecs[i].p; funcao = vecs[i].f;
      rel = vecs[i].rel; rst_n = vecs[i].rst;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got = {busy, grant, fe, deny, locked, fail};
      exp = sb.pop_front();
      check($sformatf("vec%0d", i), 32'(got), 32'(exp));
    end

    // request latency and grant window length measured with bounded waits
    @(negedge clk);
    rst_n = 1'b1; rel = 1'b0; req = 1'b1; perfil = 2'd1; funcao = 4'd0;
    @(negedge clk);
    req = 1'b0;
    check("check_not_granted", 32'(grant), 32'd0);
    lat = 1;
    while (grant !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    check("fe_latency", 32'(fe), 32'h0001);
    glen = 1;
    while (grant === 1'b1 && glen < 20) begin
      @(posedge clk); #1;
      if (grant === 1'b1) glen++;
    end
    check("grant_len", 32'(glen), 32'd4);
    check("busy_after_grant", 32'(busy), 32'd0);
    check("fe_after_grant", 32'(fe), 32'd0);

`ifdef AUDIT_COUNT_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("audit_reset_g", 32'(gtot), 32'd0);
    check("audit_reset_d", 32'(dtot), 32'd0);
    for (int i = 0; i < 3; i++) do_req(3, i);
    for (int i = 0; i < 2; i++) do_req(0, 8);
    check("audit_grants3", 32'(gtot), 32'd3);
    check("audit_denials2", 32'(dtot), 32'd2);
    for (int i = 0; i < 300; i++) do_req(1, 2);
    check("audit_grant_sat", 32'(gtot), 32'd255);
    check("audit_deny_hold", 32'(dtot), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
